mem_port_arbiter: RTL and testbench

- Arbitrates the single-ported unified instruction/data memory between the fetch stage (read-only) and the load/store stage (read/write).
- Sequences each memory access over a configurable latency and returns read data with a one-cycle done pulse.
- Data accesses win by default, because they belong to the older instruction. A starvation guard forces a fetch grant after a bounded run of data grants.
- Sits between the pipeline stages and the memory. The hazard/stall logic consumes `busy` and the done pulses.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data wins by default; a starvation guard forces fetch after a run of contested data grants.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   // fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   // load/store port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_size,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   // memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_size,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              busy,
   output logic              owner
);

   localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } state_t;

   state_t             state;
   logic [LAT_W-1:0]   lat_cnt;
   logic [STV_W-1:0]   starve_cnt;
   logic               we_lat;
   logic               starve_full;
   logic               grant_fetch;

   assign starve_full = (starve_cnt == STV_W'(STARVE_LIMIT));
   // Fetch wins when alone, or when the data side has used up its contested run.
   assign grant_fetch = if_req & (~d_req | starve_full);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         we_lat     <= 1'b0;
         if_done    <= 1'b0;
         if_rdata   <= '0;
         d_done     <= 1'b0;
         d_rdata    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_size   <= '0;
         busy       <= 1'b0;
         owner      <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         unique case (state)
            StIdle: begin
               if (if_req || d_req) begin
                  state     <= StAccess;
                  busy      <= 1'b1;
                  mem_en    <= 1'b1;
                  lat_cnt   <= LAT_W'(MEM_LATENCY - 1);
                  mem_wdata <= d_wdata;
                  if (grant_fetch) begin
                     owner      <= 1'b0;
                     we_lat     <= 1'b0;
                     mem_we     <= 1'b0;
                     mem_addr   <= if_addr;
                     mem_size   <= 3'b010;
                     starve_cnt <= '0;
                  end else begin
                     owner    <= 1'b1;
                     we_lat   <= d_we;
                     mem_we   <= d_we;
                     mem_addr <= d_addr;
                     mem_size <= d_size;
                     // Only grants that actually made fetch wait count toward starvation.
                     if (!if_req) begin
                        starve_cnt <= '0;
                     end else if (!starve_full) begin
                        starve_cnt <= starve_cnt + 1'b1;
                     end
                  end
               end
            end
            StAccess: begin
               if (lat_cnt == '0) begin
                  state  <= StResp;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (owner) begin
                     d_done <= 1'b1;
                     if (!we_lat) begin
                        d_rdata <= mem_rdata;
                     end
                  end else begin
                     if_done  <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            StResp: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: begin
               state  <= StIdle;
               busy   <= 1'b0;
               mem_en <= 1'b0;
               mem_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LATENCY=3 instance carries most scenarios,
// a MEM_LATENCY=1 instance covers the single-cycle fetch.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        is_data;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [2:0]  d_size;

   logic        if_done, d_done, mem_en, mem_we, busy, owner;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_size;

   logic        if_done1, d_done1, mem_en1, mem_we1, busy1, owner1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [2:0]  mem_size1;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   int unsigned en_cycle;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done1), .if_rdata(if_rdata1),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_done(d_done1), .d_rdata(d_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_size(mem_size1), .mem_rdata(mem_rdata1),
      .busy(busy1), .owner(owner1)
   );

   // Memory model: the word changes every enabled cycle so only the last one is correct.
   always @(posedge clk or posedge rst) begin
      if (rst) en_cycle <= 1;
      else if (mem_en) en_cycle <= en_cycle + 1;
      else en_cycle <= 1;
   end
   assign mem_rdata  = mem_en ? (mem_addr ^ 32'hA5A5_0000 ^ 32'(en_cycle)) : 32'hBAD0_BAD0;
   assign mem_rdata1 = mem_en1 ? 32'hDEAD_BEEF : 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'hA5A5_0000 ^ 32'd3;
   endfunction

   task automatic wait_done(input int budget, output logic got_if, output logic got_d,
                            output logic ok);
      got_if = 1'b0;
      got_d  = 1'b0;
      ok     = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (if_done || d_done) begin
            got_if = if_done;
            got_d  = d_done;
            ok     = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle();
      logic idle = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy && !busy1) begin
            idle = 1'b1;
            break;
         end
      end
      vectors++;
      if (!idle) begin
         miscompares++;
         $display("FAIL idle_timeout: busy=%0b busy1=%0b required both 0", busy, busy1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({busy, mem_en, mem_we, owner, if_done, d_done} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {busy, mem_en, mem_we, owner, if_done, d_done});
      end
      vectors++;
      if ({if_rdata, d_rdata, mem_addr, mem_wdata, mem_size} !== 131'b0) begin
         miscompares++;
         $display("FAIL reset_data: if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h size=%b required 0",
                  if_rdata, d_rdata, mem_addr, mem_wdata, mem_size);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || busy1 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy=%0b busy1=%0b required 0 with no request", busy, busy1);
      end
   endtask

   task automatic test_fetch_l1();
      int en_cnt = 0;
      int done_k = 0;
      logic d_seen = 1'b0;
      if_addr = 32'h10;
      if_req  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (mem_en1) begin
            en_cnt++;
            vectors++;
            if (mem_addr1 !== 32'h10) begin
               miscompares++;
               $display("FAIL l1_addr: got %h required 00000010", mem_addr1);
            end
         end
         if (d_done1) d_seen = 1'b1;
         if (if_done1 && done_k == 0) begin
            done_k = k;
            if_req = 1'b0;
            vectors++;
            if (if_rdata1 !== 32'hDEAD_BEEF) begin
               miscompares++;
               $display("FAIL l1_rdata: got %h required deadbeef", if_rdata1);
            end
         end
      end
      vectors++;
      if (en_cnt != 1 || done_k != 2 || d_seen) begin
         miscompares++;
         $display("FAIL l1_timing: en_cycles=%0d done_cycle=%0d d_done_seen=%0b required 1 2 0",
                  en_cnt, done_k, d_seen);
      end
      if_req = 1'b0;
      wait_idle();
   endtask

   task automatic test_same_cycle();
      logic got_if, got_d, ok;
      exp_t e;
      logic [31:0] pre = d_rdata;
      if_addr = 32'h40;
      if_req  = 1'b1;
      d_addr  = 32'h20;
      d_wdata = 32'h55;
      d_size  = 3'b010;
      d_we    = 1'b1;
      d_req   = 1'b1;
      sb.push_back('{is_data: 1'b1, rdata: pre});
      sb.push_back('{is_data: 1'b0, rdata: mem_word(32'h40)});
      @(negedge clk);
      vectors++;
      if ({mem_en, owner, mem_we, mem_addr, mem_wdata, mem_size} !== {3'b111, 32'h20, 32'h55, 3'b010}) begin
         miscompares++;
         $display("FAIL same_store_bus: en=%0b owner=%0b we=%0b addr=%h wdata=%h size=%b required 1 1 1 20 55 010",
                  mem_en, owner, mem_we, mem_addr, mem_wdata, mem_size);
      end
      wait_done(10, got_if, got_d, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || got_d !== e.is_data || got_if !== !e.is_data || d_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL same_store_done: ok=%0b if=%0b d=%0b d_rdata=%h required d_done only, d_rdata=%h",
                  ok, got_if, got_d, d_rdata, e.rdata);
      end
      d_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || d_done !== 1'b0) begin
         miscompares++;
         $display("FAIL same_gap: busy=%0b d_done=%0b required 0 0", busy, d_done);
      end
      @(negedge clk);
      vectors++;
      if ({mem_en, owner, mem_we, mem_addr, mem_size} !== {3'b100, 32'h40, 3'b010}) begin
         miscompares++;
         $display("FAIL same_fetch_bus: en=%0b owner=%0b we=%0b addr=%h size=%b required 1 0 0 40 010",
                  mem_en, owner, mem_we, mem_addr, mem_size);
      end
      wait_done(10, got_if, got_d, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || got_d !== e.is_data || got_if !== !e.is_data || if_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL same_fetch_done: ok=%0b if=%0b d=%0b if_rdata=%h required if_done only, if_rdata=%h",
                  ok, got_if, got_d, if_rdata, e.rdata);
      end
      if_req = 1'b0;
      wait_idle();
   endtask

   // Both ports held high; pushes the expected grant order and checks each done.
   task automatic run_contested(input string tag, input int n);
      logic got_if, got_d, ok;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         wait_done(12, got_if, got_d, ok);
         if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: grant %0d never completed", tag, i);
            break;
         end
         e = sb.pop_front();
         vectors++;
         if (got_d !== e.is_data || got_if !== !e.is_data ||
             (e.is_data ? d_rdata : if_rdata) !== e.rdata) begin
            miscompares++;
            $display("FAIL %s_grant%0d: if_done=%0b d_done=%0b rdata=%h required %s rdata=%h",
                     tag, i, got_if, got_d, e.is_data ? d_rdata : if_rdata,
                     e.is_data ? "data" : "fetch", e.rdata);
         end
      end
      sb.delete();
   endtask

   task automatic push_pattern(input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int j = 0; j < 4; j++) sb.push_back('{is_data: 1'b1, rdata: mem_word(32'h20)});
         sb.push_back('{is_data: 1'b0, rdata: mem_word(32'h40)});
      end
   endtask

   task automatic drive_both();
      if_addr = 32'h40;
      d_addr  = 32'h20;
      d_we    = 1'b0;
      d_size  = 3'b010;
      if_req  = 1'b1;
      d_req   = 1'b1;
   endtask

   task automatic test_starvation();
      drive_both();
      push_pattern(2);
      run_contested("starve", 10);
      if_req = 1'b0;
      d_req  = 1'b0;
      wait_idle();
   endtask

   task automatic test_load_l3();
      exp_t e;
      d_addr = 32'h80;
      d_we   = 1'b0;
      d_size = 3'b010;
      d_req  = 1'b1;
      sb.push_back('{is_data: 1'b1, rdata: mem_word(32'h80)});
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k <= 3) begin
            vectors++;
            if ({mem_en, busy, d_done, mem_addr} !== {3'b110, 32'h80}) begin
               miscompares++;
               $display("FAIL l3_access%0d: en=%0b busy=%0b d_done=%0b addr=%h required 1 1 0 80",
                        k, mem_en, busy, d_done, mem_addr);
            end
         end else begin
            e = sb.pop_front();
            d_req = 1'b0;
            vectors++;
            if (mem_en !== 1'b0 || d_done !== 1'b1 || if_done !== 1'b0 || d_rdata !== e.rdata) begin
               miscompares++;
               $display("FAIL l3_resp: en=%0b d_done=%0b if_done=%0b d_rdata=%h required 0 1 0 %h",
                        mem_en, d_done, if_done, d_rdata, e.rdata);
            end
         end
      end
      d_req = 1'b0;
      wait_idle();
   endtask

   task automatic test_req_dropped();
      int pulses = 0;
      exp_t e;
      d_addr = 32'h30;
      d_we   = 1'b0;
      d_req  = 1'b1;
      sb.push_back('{is_data: 1'b1, rdata: mem_word(32'h30)});
      @(negedge clk);
      d_req = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         if (d_done) begin
            pulses++;
            e = sb.pop_front();
            vectors++;
            if (d_rdata !== e.rdata) begin
               miscompares++;
               $display("FAIL drop_rdata: got %h required %h", d_rdata, e.rdata);
            end
         end
      end
      vectors++;
      if (pulses != 1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL drop_done: pulses=%0d busy=%0b required 1 0", pulses, busy);
      end
      sb.delete();
   endtask

   task automatic test_reset_mid_access();
      int dones = 0;
      drive_both();
      for (int j = 0; j < 3; j++) sb.push_back('{is_data: 1'b1, rdata: mem_word(32'h20)});
      run_contested("prerst", 3);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (mem_en !== 1'b1 || owner !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre_access: en=%0b owner=%0b required 1 1", mem_en, owner);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({busy, mem_en, mem_we, owner, if_done, d_done, if_rdata, d_rdata, mem_addr,
           mem_wdata, mem_size} !== 137'b0) begin
         miscompares++;
         $display("FAIL rst_async: busy=%0b en=%0b owner=%0b if_rdata=%h d_rdata=%h addr=%h required all 0",
                  busy, mem_en, owner, if_rdata, d_rdata, mem_addr);
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (if_done || d_done) dones++;
      end
      vectors++;
      if (dones != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_no_done: dones=%0d busy=%0b required 0 0", dones, busy);
      end
      // With starve_cnt cleared, four data grants must precede the fetch.
      drive_both();
      push_pattern(1);
      run_contested("postrst", 5);
      if_req = 1'b0;
      d_req  = 1'b0;
      wait_idle();
   endtask

   initial begin
      rst     = 1'b1;
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      d_size  = '0;
      test_reset();
      test_fetch_l1();
      test_same_cycle();
      test_starvation();
      test_load_l3();
      test_req_dropped();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
